// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM.
// Optional single-step mode (step port, PAUSE state) under `SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ir,
    input  logic                dec_regwrite,
    input  logic                dec_memaccess,
    input  logic                dec_memwrite,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                rf_we,
    output logic                busy,
    output logic                retired,
    output logic [15:0]         instr_count,
    output logic                fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED,
        S_FAULT
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    // Last wait-counter value before a missing ack becomes a fault.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          wait_q, wait_d;
    logic                retire_q, retire_d;
    logic                regwr_q, regwr_d;
    logic                memwr_q, memwr_d;
    logic                do_retire;

    // State and datapath registers; reset aborts any handshake at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            retire_q <= 1'b0;
            regwr_q  <= 1'b0;
            memwr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            regwr_q  <= regwr_d;
            memwr_q  <= memwr_d;
        end
    end

    // Next-state logic; decoder flags are latched in EXEC so MEM/WB stay stable.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        regwr_d   = regwr_q;
        memwr_d   = memwr_q;
        retire_d  = 1'b0;
        do_retire = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (start) begin
                    pc_d    = '0;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else if (step) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
`endif
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (ir_q == 32'h0) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                regwr_d = dec_regwrite;
                memwr_d = dec_memwrite;
                if (dec_memaccess) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (memwr_q) begin
                        do_retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                do_retire = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_retire) begin
            retire_d = 1'b1;
            pc_d     = pc_q + PC_WIDTH'(1);
            wait_d   = '0;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
`ifdef SEQ_SINGLE_STEP_EN
            state_d = S_PAUSE;
`else
            state_d = S_FETCH;
`endif
        end
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        dmem_req    = (state_q == S_MEM);
        dmem_we     = (state_q == S_MEM) && memwr_q;
        rf_we       = (state_q == S_WB) && regwr_q;
        busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC) || (state_q == S_MEM) ||
                      (state_q == S_WB);
        fault       = (state_q == S_FAULT);
        retired     = retire_q;
        pc          = pc_q;
        ir          = ir_q;
        instr_count = cnt_q;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed stimulus with a retire scoreboard.
// Expected retire records are queued at fetch; a negedge monitor checks them.
module tb_cpu_sequencer;

    localparam int PCW = 2;
    localparam int TMO = 15;

    typedef struct {
        int pc;
        int cnt;
        int rf;
        int dreq;
        int dwe;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic           step = 1'b0;
`endif
    logic [PCW-1:0] pc;
    logic           imem_req;
    logic           imem_ack = 1'b0;
    logic [31:0]    imem_rdata = '0;
    logic [31:0]    ir;
    logic           dec_regwrite = 1'b0;
    logic           dec_memaccess = 1'b0;
    logic           dec_memwrite = 1'b0;
    logic           dmem_req;
    logic           dmem_we;
    logic           dmem_ack = 1'b0;
    logic           rf_we;
    logic           busy;
    logic           retired;
    logic [15:0]    instr_count;
    logic           fault;

    int   vectors = 0;
    int   miscompares = 0;
    int   exp_pc = 0;
    int   exp_cnt = 0;
    exp_t exp_q[$];
    int   acc_rf = 0;
    int   acc_dreq = 0;
    int   acc_dwe = 0;

    cpu_sequencer #(.PC_WIDTH(PCW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .pc(pc),
        .imem_req(imem_req),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .ir(ir),
        .dec_regwrite(dec_regwrite),
        .dec_memaccess(dec_memaccess),
        .dec_memwrite(dec_memwrite),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_ack(dmem_ack),
        .rf_we(rf_we),
        .busy(busy),
        .retired(retired),
        .instr_count(instr_count),
        .fault(fault)
`ifdef SEQ_SINGLE_STEP_EN
        , .step(step)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-instruction activity, compare at each retire.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_rf   = 0;
            acc_dreq = 0;
            acc_dwe  = 0;
        end else begin
            acc_rf   += int'(rf_we);
            acc_dreq += int'(dmem_req);
            acc_dwe  += int'(dmem_we);
            if (retired) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("retire_pc", 32'(pc), 32'(e.pc));
                    check("retire_cnt", 32'(instr_count), 32'(e.cnt));
                    check("rf_we_pulses", 32'(acc_rf), 32'(e.rf));
                    check("dmem_req_cycles", 32'(acc_dreq), 32'(e.dreq));
                    check("dmem_we_cycles", 32'(acc_dwe), 32'(e.dwe));
`ifdef SEQ_SINGLE_STEP_EN
                    check("busy_after_retire", 32'(busy), 32'd0);
`else
                    check("busy_after_retire", 32'(busy), 32'd1);
`endif
                end
                acc_rf   = 0;
                acc_dreq = 0;
                acc_dwe  = 0;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for a fetch request; in step mode, step out of PAUSE.
    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req && n < 50) begin
`ifdef SEQ_SINGLE_STEP_EN
            step = !busy && !fault;
`endif
            @(negedge clk);
            n++;
        end
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        check("imem_req_seen", 32'(imem_req), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] w, input bit rw,
                             input bit ma, input bit mw,
                             input int idly, input int ddly,
                             input bit poke_start);
        exp_t e;
        int   n;
        wait_req();
        for (int i = 0; i < idly; i++) begin
            start = poke_start && (i == 0);
            @(negedge clk);
            start = 1'b0;
        end
        imem_ack      = 1'b1;
        imem_rdata    = w;
        dec_regwrite  = rw;
        dec_memaccess = ma;
        dec_memwrite  = mw;
        exp_pc  = (exp_pc + 1) % (1 << PCW);
        exp_cnt = exp_cnt + 1;
        e.pc   = exp_pc;
        e.cnt  = exp_cnt;
        e.rf   = (rw && !(ma && mw)) ? 1 : 0;
        e.dreq = ma ? ddly + 1 : 0;
        e.dwe  = (ma && mw) ? ddly + 1 : 0;
        exp_q.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0;
        if (ma) begin
            n = 0;
            while (!dmem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("dmem_req_seen", 32'(dmem_req), 32'd1);
            repeat (ddly) @(negedge clk);
            dmem_ack = 1'b1;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_cnt", 32'(instr_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();

        // ALU, load (ack delayed 3), store, wrap with start poke, more ALU
        run_instr(32'h0000_1000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(32'h0000_2003, 1'b1, 1'b1, 1'b0, 0, 3, 1'b0);
        run_instr(32'h0000_3023, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0);
        run_instr(32'h0000_4013, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
        run_instr(32'h0000_5013, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
        run_instr(32'h0000_6013, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        // HALT word: no retire, pc and ir hold, stray ack ignored
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("halt_decode_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("halted_busy", 32'(busy), 32'd0);
        check("halted_ir", ir, 32'd0);
        check("halted_pc", 32'(pc), 32'(exp_pc));
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("halted_stray_ack_busy", 32'(busy), 32'd0);
        check("halted_stray_ack_pc", 32'(pc), 32'(exp_pc));
        pulse_start();
        exp_pc = 0;
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_imem_req", 32'(imem_req), 32'd1);

        // Ack on exactly the last allowed request cycle: no fault
        run_instr(32'h0000_7013, 1'b1, 1'b0, 1'b0, TMO - 1, 0, 1'b0);
        check("late_ack_no_fault", 32'(fault), 32'd0);

        // Withheld ack: fault after TMO waiting cycles, sticky
        wait_req();
        repeat (TMO - 1) @(negedge clk);
        check("last_wait_req", 32'(imem_req), 32'd1);
        check("last_wait_fault", 32'(fault), 32'd0);
        @(negedge clk);
        check("timeout_fault", 32'(fault), 32'd1);
        check("timeout_req_low", 32'(imem_req), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        pulse_start();
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_no_req", 32'(imem_req), 32'd0);

        // Reset clears fault; reset mid-request drops imem_req at once
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_clears_fault", 32'(fault), 32'd0);
        check("rst_clears_cnt", 32'(instr_count), 32'd0);
        rst_n = 1'b1;
        exp_pc  = 0;
        exp_cnt = 0;
        pulse_start();
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();

        // Five ALU ops with a 2-bit pc: 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            run_instr(32'h0000_0013 + 32'(i), 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        end

        repeat (8) @(negedge clk);
        check("final_cnt", 32'(instr_count), 32'd5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
